// File: rtl/seq_shifter_pkg.sv
// Shared definitions for the sequential shifter: mode encodings and FSM states.
package seq_shifter_pkg;

   localparam logic [1:0] ROT_R = 2'b00;
   localparam logic [1:0] ROT_L = 2'b01;
   localparam logic [1:0] SHR   = 2'b10;
   localparam logic [1:0] SHL   = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/seq_shifter_shift_step.sv
// Combinational single-bit step unit: one rotate or shift position per evaluation.
module shift_step
   import seq_shifter_pkg::*;
#(
   parameter int N = 8
)
(
   input  logic [N-1:0] W,
   input  logic [1:0]   mode,
   input  logic         arith,
   output logic [N-1:0] W_next
);

   // Arithmetic fill only matters for right shifts; other modes ignore arith.
   always_comb begin
      W_next = W;
      case (mode)
         ROT_R: W_next = {W[0], W[N-1:1]};
         ROT_L: W_next = {W[N-2:0], W[N-1]};
         SHR:   W_next = {arith & W[N-1], W[N-1:1]};
         SHL:   W_next = {W[N-2:0], 1'b0};
      endcase
   end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter/rotator: one bit position per clock under a start/ready handshake,
// with a registered result and a one-cycle done pulse.
module seq_shifter
   import seq_shifter_pkg::*;
#(
   parameter int N   = 8,
   parameter int SHW = $clog2(N)
)
(
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   A,
   input  logic [SHW-1:0] amt,
   input  logic [1:0]     mode,
   input  logic           arith,
   output logic           ready,
   output logic           busy,
   output logic           done,
   output logic [N-1:0]   RS
);

   state_t         state_q, state_d;
   logic [N-1:0]   work_q, work_d;
   logic [N-1:0]   rs_q, rs_d;
   logic [SHW-1:0] cnt_q, cnt_d;
   logic [1:0]     mode_q, mode_d;
   logic           arith_q, arith_d;
   logic [N-1:0]   stepped;

   shift_step #(.N(N)) u_step (
      .W      (work_q),
      .mode   (mode_q),
      .arith  (arith_q),
      .W_next (stepped)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         work_q  <= '0;
         rs_q    <= '0;
         cnt_q   <= '0;
         mode_q  <= ROT_R;
         arith_q <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         rs_q    <= rs_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         arith_q <= arith_d;
      end
   end

   // The result register is written only on the transition into DONE, so RS holds between pulses.
   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      rs_d    = rs_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      arith_d = arith_q;
      ready   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               work_d  = A;
               cnt_d   = amt;
               mode_d  = mode;
               arith_d = arith;
               if (amt == '0) begin
                  rs_d    = A;
                  state_d = DONE;
               end else begin
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            busy   = 1'b1;
            work_d = stepped;
            cnt_d  = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
               rs_d    = stepped;
               state_d = DONE;
            end
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign RS = rs_q;

endmodule
